// File: rtl/trng_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trng_conditioner: synchronise and sample a ring-oscillator bit, von Neumann
// debias it, pack into bytes on valid/ready; repetition-count health test.
// Revision: 1.0
// ---------------------------------------------------------------------------
module trng_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DIV  = 4,
  parameter int REP_LIMIT   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rnd_raw,
  input  logic       fault_clr,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       fault
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

  typedef enum logic [0:0] {
    PAIR_FIRST  = 1'b0,
    PAIR_SECOND = 1'b1
  } pair_state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DIV_W-1:0]       r_div;
  pair_state_t            r_pair, w_pair;
  logic                   r_first, w_first;
  logic [REP_W-1:0]       r_rep, w_rep;
  logic                   r_last, w_last;
  logic                   r_fault, w_fault;
  logic [7:0]             r_sr, w_sr;
  logic [3:0]             r_cnt, w_cnt;
  logic [7:0]             r_out, w_out;
  logic                   r_valid, w_valid;
  logic                   w_s;
  logic                   w_strobe;
  logic                   w_emit;
  logic                   w_load;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_strobe = en && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_div  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rnd_raw};
      if (!en || w_strobe) r_div <= '0;
      else                 r_div <= r_div + 1'b1;
    end
  end

  // Repetition-count health test; a clear overrides a same-cycle detection.
  always_comb begin
    w_rep   = r_rep;
    w_last  = r_last;
    w_fault = r_fault;
    if (w_strobe) begin
      if (w_s != r_last)        w_rep = REP_W'(1);
      else if (r_rep != REP_MAX) w_rep = r_rep + 1'b1;
      w_last = w_s;
      if (w_rep == REP_MAX) w_fault = 1'b1;
    end
    if (fault_clr) begin
      w_fault = 1'b0;
      w_rep   = '0;
    end
  end

  // Von Neumann pair extractor.
  always_comb begin
    w_pair  = r_pair;
    w_first = r_first;
    w_emit  = 1'b0;
    if (!en || r_fault || fault_clr) begin
      w_pair = PAIR_FIRST;
    end else if (w_strobe) begin
      case (r_pair)
        PAIR_FIRST: begin
          w_first = w_s;
          w_pair  = PAIR_SECOND;
        end
        PAIR_SECOND: begin
          w_emit = (w_s != r_first);
          w_pair = PAIR_FIRST;
        end
        default: w_pair = PAIR_FIRST;
      endcase
    end
  end

  assign w_load = (r_cnt == 4'd8) && (!r_valid || byte_ready) && !r_fault;

  // Packing and holding register; a bit emitted during a load starts the next byte.
  always_comb begin
    w_sr    = r_sr;
    w_cnt   = r_cnt;
    w_out   = r_out;
    w_valid = r_valid;
    if (r_valid && byte_ready) w_valid = 1'b0;
    if (w_load) begin
      w_out   = r_sr;
      w_valid = 1'b1;
      w_cnt   = '0;
    end
    if (w_emit && (w_cnt != 4'd8)) begin
      w_sr  = {r_sr[6:0], r_first};
      w_cnt = w_cnt + 1'b1;
    end
    if (w_fault) begin
      w_sr    = '0;
      w_cnt   = '0;
      w_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair  <= PAIR_FIRST;
      r_first <= 1'b0;
      r_rep   <= '0;
      r_last  <= 1'b0;
      r_fault <= 1'b0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_pair  <= w_pair;
      r_first <= w_first;
      r_rep   <= w_rep;
      r_last  <= w_last;
      r_fault <= w_fault;
      r_sr    <= w_sr;
      r_cnt   <= w_cnt;
      r_out   <= w_out;
      r_valid <= w_valid;
    end
  end

  assign byte_out   = r_out;
  assign byte_valid = r_valid;
  assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_trng_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trng_conditioner: directed vectors on a SAMPLE_DIV=1 instance plus
// randomized stimulus on a default instance, both against a reference model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_trng_conditioner;

  localparam int SYNC = 2;
  localparam int REP  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       en1, raw1, clr1, rdy1, valid1, fault1;
  logic [7:0] out1;
  logic       en4, raw4, clr4, rdy4, valid4, fault4;
  logic [7:0] out4;

  trng_conditioner #(.SYNC_STAGES(SYNC), .SAMPLE_DIV(1), .REP_LIMIT(REP)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .rnd_raw(raw1), .fault_clr(clr1),
    .byte_ready(rdy1), .byte_out(out1), .byte_valid(valid1), .fault(fault1));

  trng_conditioner dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .rnd_raw(raw4), .fault_clr(clr4),
    .byte_ready(rdy4), .byte_out(out4), .byte_valid(valid4), .fault(fault4));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vcnt    = 0;
  int f4_seen = 0;
  bit rand_done = 1'b0;
  logic [7:0] q[$];
  int tcyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain per-cycle bookkeeping of the documented rules.
  typedef struct packed {
    logic [7:0]  hist;
    logic [31:0] ticks;
    logic [31:0] run;
    logic        last;
    logic        half;
    logic        fb;
    logic [7:0]  acc;
    logic [31:0] nb;
    logic [7:0]  ob;
    logic        ov;
    logic        flt;
  } mstate_t;

  function automatic mstate_t model_next(mstate_t m, int div, int sync, int replim,
                                         logic en, logic raw, logic clr, logic rdy);
    mstate_t n = m;
    logic s, strobe, got, fset;
    s      = m.hist[sync-1];
    strobe = en && ((int'(m.ticks) % div) == div - 1);
    n.hist  = {m.hist[6:0], raw};
    n.ticks = en ? m.ticks + 32'd1 : 32'd0;
    fset = 1'b0;
    if (strobe) begin
      if (s != m.last) n.run = 32'd1;
      else if (int'(m.run) < replim) n.run = m.run + 32'd1;
      n.last = s;
      if (int'(n.run) == replim) fset = 1'b1;
    end
    n.flt = m.flt | fset;
    if (clr) begin
      n.flt = 1'b0;
      n.run = 32'd0;
    end
    got = 1'b0;
    if (!en || m.flt || clr) n.half = 1'b0;
    else if (strobe) begin
      if (!m.half) begin
        n.half = 1'b1;
        n.fb   = s;
      end else begin
        n.half = 1'b0;
        got    = (s != m.fb);
      end
    end
    if (m.ov && rdy) n.ov = 1'b0;
    if (m.nb == 32'd8 && (!m.ov || rdy) && !m.flt) begin
      n.ob = m.acc;
      n.ov = 1'b1;
      n.nb = 32'd0;
    end
    if (got && n.nb < 32'd8) begin
      n.acc = {m.acc[6:0], m.fb};
      n.nb  = n.nb + 32'd1;
    end
    if (n.flt) begin
      n.acc = 8'd0;
      n.nb  = 32'd0;
      n.ov  = 1'b0;
    end
    return n;
  endfunction

  mstate_t m1, m4;

  initial begin
    m1 = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) m1 = '0;
      else m1 = model_next(m1, 1, SYNC, REP, en1, raw1, clr1, rdy1);
      @(negedge clk);
      if (!rst_n) m1 = '0;
      chk("d1_byte_out", 32'(out1), 32'(m1.ob));
      chk("d1_byte_valid", 32'(valid1), 32'(m1.ov));
      chk("d1_fault", 32'(fault1), 32'(m1.flt));
    end
  end

  initial begin
    m4 = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) m4 = '0;
      else m4 = model_next(m4, 4, 2, 32, en4, raw4, clr4, rdy4);
      @(negedge clk);
      if (!rst_n) m4 = '0;
      if (fault4) f4_seen++;
      chk("d4_byte_out", 32'(out4), 32'(m4.ob));
      chk("d4_byte_valid", 32'(valid4), 32'(m4.ov));
      chk("d4_fault", 32'(fault4), 32'(m4.flt));
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && valid1) begin
      vcnt++;
      if (rdy1) begin
        q.push_back(out1);
        tcyc.push_back(cyc);
      end
    end
  end

  // Random traffic with periodic stuck phases and fault clears.
  initial begin
    en4 = 1'b0; raw4 = 1'b0; clr4 = 1'b0; rdy4 = 1'b0;
    @(posedge rst_n);
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      en4  = ($urandom_range(0, 15) != 0);
      if ((c % 1200) >= 600 && (c % 1200) < 800) raw4 = 1'b1;
      else raw4 = 1'($urandom_range(0, 1));
      rdy4 = ($urandom_range(0, 3) != 0);
      clr4 = ((c % 1200) == 900) || ($urandom_range(0, 499) == 0);
    end
    rand_done = 1'b1;
  end

  // Bits are applied first-first; en opens only while they sit at the synchroniser output.
  task automatic feed(input logic [31:0] bits, input int n);
    for (int i = 0; i < n + SYNC; i++) begin
      raw1 = (i < n) ? bits[n-1-i] : 1'b0;
      en1  = (i >= SYNC);
      @(posedge clk); #1;
    end
    en1  = 1'b0;
    raw1 = 1'b0;
  endtask

  task automatic clear_mon();
    q.delete();
    tcyc.delete();
    vcnt = 0;
  endtask

  task automatic check_one(input string nm, input logic [7:0] exp);
    repeat (6) @(posedge clk);
    #1;
    chk({nm, "_count"}, 32'(q.size()), 32'd1);
    if (q.size() > 0) chk({nm, "_value"}, 32'(q[0]), 32'(exp));
    chk({nm, "_valid_cycles"}, 32'(vcnt), 32'd1);
    clear_mon();
  endtask

  typedef struct {
    logic [31:0] bits;
    int          n;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[5];
  int   kf;

  initial begin
    vecs[0] = '{32'b10011010_01011100_1001, 20, 8'hB2};
    vecs[1] = '{32'b01100101_10100110,      16, 8'h4D};
    vecs[2] = '{32'b10111000_10101010_1010, 20, 8'hFF};
    vecs[3] = '{32'b01010101_01010101,      16, 8'h00};
    vecs[4] = '{32'b10010110_01101001,      16, 8'h96};

    en1 = 1'b0; raw1 = 1'b0; clr1 = 1'b0; rdy1 = 1'b1;
    #1 rst_n = 1'b0;

    // Reset holds outputs at zero even with activity on the inputs.
    en1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      raw1 = ~raw1;
      @(negedge clk);
      chk("rst_byte_out", 32'(out1), 32'h00);
      chk("rst_byte_valid", 32'(valid1), 32'd0);
      chk("rst_fault", 32'(fault1), 32'd0);
    end
    @(posedge clk); #1;
    en1 = 1'b0; raw1 = 1'b0;
    rst_n = 1'b1;
    clear_mon();

    // Seven good pairs are one short of a byte; the eighth completes 0xFF.
    feed(32'b10101010101010, 14);
    repeat (4) @(posedge clk);
    #1;
    chk("early_no_byte", 32'(vcnt), 32'd0);
    feed(32'b10, 2);
    check_one("first_byte", 8'hFF);

    for (int v = 0; v < 5; v++) begin
      feed(vecs[v].bits, vecs[v].n);
      check_one($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Stuck source: 32 identical samples trip the fault.
    raw1 = 1'b1; en1 = 1'b1; kf = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (fault1 && kf < 0) kf = k;
      @(posedge clk); #1;
    end
    en1 = 1'b0; raw1 = 1'b0;
    chk("stuck_fault_cycle", 32'(kf), 32'd34);
    chk("stuck_no_valid", 32'(vcnt), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fault_sticky", 32'(fault1), 32'd1);
    @(posedge clk); #1;
    clr1 = 1'b1;
    @(posedge clk); #1;
    clr1 = 1'b0;
    @(negedge clk);
    chk("fault_cleared", 32'(fault1), 32'd0);
    @(posedge clk); #1;
    clear_mon();
    feed(vecs[0].bits, vecs[0].n);
    check_one("after_clear", 8'hB2);

    // Backpressure: second byte waits in the packer, surplus bits dropped.
    rdy1 = 1'b0;
    feed(vecs[0].bits, vecs[0].n);
    feed(vecs[1].bits, vecs[1].n);
    feed(32'b1010, 4);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_valid_held", 32'(valid1), 32'd1);
    chk("bp_byte_held", 32'(out1), 32'hB2);
    chk("bp_no_transfer", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    rdy1 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_count", 32'(q.size()), 32'd2);
    if (q.size() == 2) begin
      chk("bp_first", 32'(q[0]), 32'hB2);
      chk("bp_second", 32'(q[1]), 32'h4D);
      chk("bp_no_bubble", 32'(tcyc[1] - tcyc[0]), 32'd1);
    end
    clear_mon();
    feed(vecs[4].bits, vecs[4].n);
    check_one("bp_drop", 8'h96);

    // en dropped mid-pair: half pair discarded, packed bits kept.
    feed(32'b01100101101, 11);
    for (int i = 0; i < 10; i++) begin
      raw1 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    raw1 = 1'b0;
    chk("en_gap_no_byte", 32'(vcnt), 32'd0);
    feed(32'b100110, 6);
    check_one("en_gate", 8'h4D);

    // Asynchronous reset with a byte pending and five bits packed.
    rdy1 = 1'b0;
    feed(vecs[0].bits, vecs[0].n);
    feed(32'b1010101010, 10);
    @(negedge clk);
    chk("pre_rst_valid", 32'(valid1), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_byte_out", 32'(out1), 32'h00);
    chk("async_rst_valid", 32'(valid1), 32'd0);
    chk("async_rst_fault", 32'(fault1), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy1  = 1'b1;
    clear_mon();
    feed(vecs[4].bits, vecs[4].n);
    check_one("post_rst", 8'h96);

    for (int i = 0; i < 20000 && !rand_done; i++) @(posedge clk);
    chk("random_done", 32'(rand_done), 32'd1);
    chk("random_fault_exercised", 32'(f4_seen > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
